// File: rtl/cpu_pkg.sv
// Shared CPU types: pipeline state, ALU operation and the data-RAM arbiter state.
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4
    } State;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_AND    = 4'd2,
        OP_OR     = 4'd3,
        OP_XOR    = 4'd4,
        OP_LOAD   = 4'd5,
        OP_STORE  = 4'd6,
        OP_BRANCH = 4'd7
    } Operation;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } ArbState;

endpackage

// File: rtl/arb_pick2.sv
// Two-way winner pick: a lone requester wins, a tie goes to the side named by prio.
module arb_pick2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] win_c
);

    always_comb begin
        win_c = req;
        if (&req) begin
            win_c = prio ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a 1-cycle-latency single-port data RAM.
// MEM_ARB_ROUND_ROBIN_EN: alternate tie priority; otherwise requester 0 always wins ties.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              _iClk,
    input  logic              _iReset,
    input  logic              _iReq0,
    input  logic              _iReq1,
    input  logic              _iWrite0,
    input  logic              _iWrite1,
    input  logic [ADDR_W-1:0] _iAddr0,
    input  logic [ADDR_W-1:0] _iAddr1,
    input  logic [DATA_W-1:0] _iWData0,
    input  logic [DATA_W-1:0] _iWData1,
    output logic              _oGnt0,
    output logic              _oGnt1,
    output logic [DATA_W-1:0] _oRData0,
    output logic [DATA_W-1:0] _oRData1,
    output logic              _oRValid0,
    output logic              _oRValid1,
    output logic [ADDR_W-1:0] _oDataMemAddr,
    output logic [DATA_W-1:0] _oDataMemWData,
    output logic              _oDataMemWrite,
    input  logic [DATA_W-1:0] _iDataMemRData
);

    ArbState           state;
    ArbState           stateNext;
    logic [1:0]        reqVec;
    logic [1:0]        win;
    logic              prio;
    logic              owner;
    logic              opWrite;
    logic              captureEn;
    logic              respEn;
    logic              pickWrite;
    logic [ADDR_W-1:0] pickAddr;
    logic [DATA_W-1:0] pickWData;

    assign reqVec = {_iReq1, _iReq0};

    arb_pick2 uPick (
        .req   (reqVec),
        .prio  (prio),
        .win_c (win)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Points at the requester that should win the next tie.
    logic rrPtr;

    always_ff @(posedge _iClk or negedge _iReset) begin
        if (!_iReset) begin
            rrPtr <= 1'b0;
        end else if (captureEn) begin
            rrPtr <= win[0];
        end
    end

    assign prio = rrPtr;
`else
    assign prio = 1'b0;
`endif

    always_ff @(posedge _iClk or negedge _iReset) begin
        if (!_iReset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (|reqVec) stateNext = ACCESS;
            ACCESS:  stateNext = RESP;
            RESP:    stateNext = (|reqVec) ? ACCESS : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // IDLE and RESP both accept a new request; RESP also returns read data.
    always_comb begin
        captureEn = 1'b0;
        respEn    = 1'b0;
        pickWrite = win[1] ? _iWrite1 : _iWrite0;
        pickAddr  = win[1] ? _iAddr1  : _iAddr0;
        pickWData = win[1] ? _iWData1 : _iWData0;
        case (state)
            IDLE: begin
                captureEn = |reqVec;
            end
            RESP: begin
                captureEn = |reqVec;
                respEn    = ~opWrite;
            end
            default: begin
                captureEn = 1'b0;
                respEn    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge _iClk or negedge _iReset) begin
        if (!_iReset) begin
            _oGnt0         <= 1'b0;
            _oGnt1         <= 1'b0;
            _oRData0       <= '0;
            _oRData1       <= '0;
            _oRValid0      <= 1'b0;
            _oRValid1      <= 1'b0;
            _oDataMemAddr  <= '0;
            _oDataMemWData <= '0;
            _oDataMemWrite <= 1'b0;
            owner          <= 1'b0;
            opWrite        <= 1'b0;
        end else begin
            _oGnt0         <= captureEn & win[0];
            _oGnt1         <= captureEn & win[1];
            _oDataMemWrite <= captureEn & pickWrite;
            if (captureEn) begin
                _oDataMemAddr  <= pickAddr;
                _oDataMemWData <= pickWData;
                owner          <= win[1];
                opWrite        <= pickWrite;
            end
            _oRValid0 <= respEn & ~owner;
            _oRValid1 <= respEn & owner;
            if (respEn && !owner) _oRData0 <= _iDataMemRData;
            if (respEn && owner)  _oRData1 <= _iDataMemRData;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-scheduling reference model.
module tb_mem_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int NCYC = 4096;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wd0 = '0, wd1 = '0;
    logic          gnt0, gnt1, rv0, rv1, memWr;
    logic [DW-1:0] rd0, rd1, memWd, memRd;
    logic [AW-1:0] memAddr;

    int nVec = 0;
    int nErr = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        ._iClk          (clk),
        ._iReset        (rstN),
        ._iReq0         (req0),
        ._iReq1         (req1),
        ._iWrite0       (wr0),
        ._iWrite1       (wr1),
        ._iAddr0        (addr0),
        ._iAddr1        (addr1),
        ._iWData0       (wd0),
        ._iWData1       (wd1),
        ._oGnt0         (gnt0),
        ._oGnt1         (gnt1),
        ._oRData0       (rd0),
        ._oRData1       (rd1),
        ._oRValid0      (rv0),
        ._oRValid1      (rv1),
        ._oDataMemAddr  (memAddr),
        ._oDataMemWData (memWd),
        ._oDataMemWrite (memWr),
        ._iDataMemRData (memRd)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] preload(input logic [7:0] a);
        case (a)
            8'h10:   return 8'hA5;
            8'h40:   return 8'h77;
            8'h50:   return 8'h11;
            default: return a ^ 8'h5A;
        endcase
    endfunction

    // Data RAM seen by the DUT: synchronous, read-before-write, 1-cycle latency.
    logic [7:0] ram [0:255];
    logic       ramInit = 1'b0;
    always @(posedge clk) begin
        if (!ramInit) begin
            for (int i = 0; i < 256; i++) ram[i] = preload(8'(i));
            ramInit = 1'b1;
        end
        memRd <= ram[memAddr];
        if (memWr) ram[memAddr] = memWd;
    end

    // Reference model: each accepted request schedules its visible effects
    // (grant and RAM drive one cycle later, read data three cycles later).
    logic [1:0] expGnt [0:NCYC-1] = '{default: '0};
    logic       expWr  [0:NCYC-1] = '{default: '0};
    logic [7:0] expAddr[0:NCYC-1] = '{default: '0};
    logic [7:0] expWd  [0:NCYC-1] = '{default: '0};
    logic [1:0] expRv  [0:NCYC-1] = '{default: '0};
    logic [7:0] expRd  [0:NCYC-1] = '{default: '0};
    logic [7:0] modelMem [0:255];
    logic       mdlInit = 1'b0;
    int         cyc = 0;
    int         nextAccept = 0;
    int         mdlEdge = 0;
    logic       lastGrant = 1'b1;
    logic       pendWr = 1'b0;
    int         pendEdge = 0;
    logic [7:0] pendAddr = '0, pendData = '0;
    logic       mdlW = 1'b0;
    logic [7:0] mdlA = '0;

    always @(posedge clk or negedge rstN) begin
        if (!mdlInit) begin
            for (int i = 0; i < 256; i++) modelMem[i] = preload(8'(i));
            mdlInit = 1'b1;
        end
        if (!rstN) begin
            for (int i = cyc; i < NCYC; i++) begin
                expGnt[i] = '0; expWr[i] = 1'b0; expRv[i] = '0;
            end
            pendWr     = 1'b0;
            nextAccept = 0;
            lastGrant  = 1'b1;
        end else begin
            mdlEdge = cyc;
            cyc     = cyc + 1;
            if (pendWr && pendEdge == mdlEdge) begin
                modelMem[pendAddr] = pendData;
                pendWr = 1'b0;
            end
            if (mdlEdge >= nextAccept && (req0 || req1) && mdlEdge + 3 < NCYC) begin
                if (req0 && req1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    mdlW = ~lastGrant;
`else
                    mdlW = 1'b0;
`endif
                end else begin
                    mdlW = req1;
                end
                lastGrant = mdlW;
                mdlA = mdlW ? addr1 : addr0;
                expGnt[mdlEdge+1]  = mdlW ? 2'b10 : 2'b01;
                expAddr[mdlEdge+1] = mdlA;
                if (mdlW ? wr1 : wr0) begin
                    expWr[mdlEdge+1] = 1'b1;
                    expWd[mdlEdge+1] = mdlW ? wd1 : wd0;
                    pendWr   = 1'b1;
                    pendEdge = mdlEdge + 1;
                    pendAddr = mdlA;
                    pendData = mdlW ? wd1 : wd0;
                end else begin
                    expRv[mdlEdge+3] = mdlW ? 2'b10 : 2'b01;
                    expRd[mdlEdge+3] = modelMem[mdlA];
                end
                nextAccept = mdlEdge + 2;
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    logic [7:0] curExp0 = '0, curExp1 = '0;
    int         cIdx = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rstN) begin
                curExp0 = '0;
                curExp1 = '0;
            end else if (cyc < NCYC) begin
                cIdx = cyc;
                check("gnt", 64'({gnt1, gnt0}), 64'(expGnt[cIdx]));
                check("memWrite", 64'(memWr), 64'(expWr[cIdx]));
                if (expGnt[cIdx] != 2'b00) check("memAddr", 64'(memAddr), 64'(expAddr[cIdx]));
                if (expWr[cIdx]) check("memWData", 64'(memWd), 64'(expWd[cIdx]));
                check("rValid", 64'({rv1, rv0}), 64'(expRv[cIdx]));
                if (expRv[cIdx][0]) curExp0 = expRd[cIdx];
                if (expRv[cIdx][1]) curExp1 = expRd[cIdx];
                check("rData0", 64'(rd0), 64'(curExp0));
                check("rData1", 64'(rd1), 64'(curExp1));
                check("gntExclusive", 64'(gnt0 & gnt1), 64'(0));
                check("validExclusive", 64'(rv0 & rv1), 64'(0));
                check("writeOnlyInAccess", 64'(memWr & ~(gnt0 | gnt1)), 64'(0));
            end
        end
    end

    task automatic setReq(input int n, input logic on, input logic wr,
                          input logic [7:0] a, input logic [7:0] d);
        if (n == 0) begin
            req0 = on; wr0 = wr; addr0 = a; wd0 = d;
        end else begin
            req1 = on; wr1 = wr; addr1 = a; wd1 = d;
        end
    endtask

    task automatic waitGnt(input int n);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if ((n == 0) ? gnt0 : gnt1) ok = 1'b1;
        end
        if (!ok) begin
            nVec++;
            nErr++;
            $display("FAIL grantTimeout: requester %0d got no grant within 20 cycles", n);
        end
    endtask

    task automatic doRead(input int n, input logic [7:0] a, output logic [7:0] d);
        setReq(n, 1'b1, 1'b0, a, 8'h00);
        waitGnt(n);
        setReq(n, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        @(negedge clk);
        check("readValidLit", 64'((n == 0) ? rv0 : rv1), 64'(1));
        d = (n == 0) ? rd0 : rd1;
    endtask

    logic [7:0] rdv;
    int         gq[$];
    int         cnt;
    int         wcnt;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("resetOuts", 64'({gnt0, gnt1, rv0, rv1, memWr, rd0, rd1, memAddr, memWd}), 64'(0));
        #2 rstN = 1'b1;

        // Basic read: grant one cycle after the request, data three cycles after.
        @(negedge clk);
        setReq(0, 1'b1, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        check("A_gnt0", 64'(gnt0), 64'(1));
        check("A_addr", 64'(memAddr), 64'(8'h10));
        setReq(0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        check("A_notYetValid", 64'(rv0), 64'(0));
        @(negedge clk);
        check("A_rvalid", 64'(rv0), 64'(1));
        check("A_rdata", 64'(rd0), 64'(8'hA5));

        // Write from requester 1, then read it back from both sides.
        @(negedge clk);
        setReq(1, 1'b1, 1'b1, 8'h20, 8'h3C);
        waitGnt(1);
        check("B_write", 64'(memWr), 64'(1));
        check("B_addr", 64'(memAddr), 64'(8'h20));
        check("B_wdata", 64'(memWd), 64'(8'h3C));
        setReq(1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        check("B_writeOneCycle", 64'(memWr), 64'(0));
        @(negedge clk);
        check("B_noValid", 64'(rv1), 64'(0));
        doRead(0, 8'h20, rdv);
        check("B_readBack0", 64'(rdv), 64'(8'h3C));
        doRead(1, 8'h20, rdv);
        check("B_readBack1", 64'(rdv), 64'(8'h3C));

        // Both requesting continuously.
        @(negedge clk);
        setReq(0, 1'b1, 1'b0, 8'h10, 8'h00);
        setReq(1, 1'b1, 1'b0, 8'h20, 8'h00);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (gnt0) gq.push_back(0);
            if (gnt1) gq.push_back(1);
        end
        setReq(0, 1'b0, 1'b0, 8'h00, 8'h00);
        setReq(1, 1'b0, 1'b0, 8'h00, 8'h00);
        check("C_grantCount", 64'(gq.size()), 64'(8));
        for (int i = 0; i < gq.size(); i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            check("C_grantOrder", 64'(gq[i]), 64'(i % 2));
`else
            check("C_grantOrder", 64'(gq[i]), 64'(0));
`endif
        end
        repeat (4) @(negedge clk);

        // Requester 0 withdraws a write while requester 1 owns the RAM.
        setReq(1, 1'b1, 1'b0, 8'h30, 8'h00);
        waitGnt(1);
        setReq(1, 1'b0, 1'b0, 8'h00, 8'h00);
        setReq(0, 1'b1, 1'b1, 8'h40, 8'hEE);
        @(negedge clk);
        setReq(0, 1'b0, 1'b0, 8'h00, 8'h00);
        cnt  = 0;
        wcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (gnt0) cnt++;
            if (memWr) wcnt++;
        end
        check("D_noGnt0", 64'(cnt), 64'(0));
        check("D_noWrite", 64'(wcnt), 64'(0));
        doRead(1, 8'h40, rdv);
        check("D_ramUntouched", 64'(rdv), 64'(8'h77));

        // Reset in the middle of a write access.
        @(negedge clk);
        setReq(0, 1'b1, 1'b1, 8'h50, 8'h99);
        waitGnt(0);
        check("E_writeActive", 64'(memWr), 64'(1));
        setReq(0, 1'b0, 1'b0, 8'h00, 8'h00);
        #2 rstN = 1'b0;
        #1;
        check("E_writeDropped", 64'(memWr), 64'(0));
        check("E_resetOuts", 64'({gnt0, gnt1, rv0, rv1, memWr, rd0, rd1, memAddr, memWd}), 64'(0));
        @(negedge clk);
        @(negedge clk);
        check("E_stillReset", 64'({gnt0, gnt1, rv0, rv1, memWr}), 64'(0));
        #2 rstN = 1'b1;

        // First tie after reset goes to requester 0.
        @(negedge clk);
        setReq(0, 1'b1, 1'b0, 8'h10, 8'h00);
        setReq(1, 1'b1, 1'b0, 8'h20, 8'h00);
        @(negedge clk);
        check("F_tieGnt", 64'({gnt1, gnt0}), 64'(2'b01));
        setReq(0, 1'b0, 1'b0, 8'h00, 8'h00);
        setReq(1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (4) @(negedge clk);
        doRead(1, 8'h50, rdv);
        check("E_ramUnchanged", 64'(rdv), 64'(8'h11));

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
